// File: rtl/fifo_rx_stream_adapter.sv
// Read-side consumer of the 8-entry async FIFO: pops show-ahead data into a 2-entry skid buffer
// and presents it as a registered valid/ready stream. Optional counters under FIFO_RX_ADAPT_STAT_EN.
module fifo_rx_stream_adapter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    output logic                  fifo_pop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic                  flush_done
`ifdef FIFO_RX_ADAPT_STAT_EN
    ,
    output logic [31:0]           stat_delivered,
    output logic [31:0]           stat_discarded
`endif
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [DATA_WIDTH-1:0] entry_r     [2];
    logic [DATA_WIDTH-1:0] entry_nxt_s [2];
    logic                  head_r;
    logic                  head_nxt_s;
    logic                  tail_r;
    logic                  tail_nxt_s;
    logic [1:0]            count_r;
    logic [1:0]            count_nxt_s;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  pop_s;
    logic                  capture_s;
    logic                  accept_s;
    logic [1:0]            dropped_s;

`ifdef FIFO_RX_ADAPT_STAT_EN
    logic [31:0]           stat_delivered_r;
    logic [31:0]           stat_discarded_r;
    logic [1:0]            discard_inc_s;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction
`endif

    // Pop request: uses only registered occupancy and fifo_empty, so out_ready never reaches the FIFO.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_RUN:   pop_s = ~fifo_empty & (count_r < 2'd2);
            ST_FLUSH: pop_s = ~fifo_empty;
            default:  pop_s = 1'b0;
        endcase
    end

    // Pop is forced low while reset is asserted, without waiting for a clock edge.
    always_comb begin
        fifo_pop   = nrst & pop_s;
        capture_s  = pop_s & (state_r == ST_RUN);
        accept_s   = out_valid_r & out_ready;
        flush_done = (state_r == ST_FLUSH) & fifo_empty & (count_r == 2'd0);
        out_valid  = out_valid_r;
        out_data   = out_data_r;
    end

    // Skid buffer bookkeeping and RUN/FLUSH sequencing.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        entry_nxt_s = entry_r;
        dropped_s   = 2'd0;
        case (state_r)
            ST_RUN: begin
                if (capture_s) begin
                    entry_nxt_s[tail_r] = fifo_do;
                    tail_nxt_s          = ~tail_r;
                end else begin
                    tail_nxt_s          = tail_r;
                end
                if (accept_s) begin
                    head_nxt_s = ~head_r;
                end else begin
                    head_nxt_s = head_r;
                end
                count_nxt_s = count_r + {1'b0, capture_s} - {1'b0, accept_s};
                // Entering FLUSH drops whatever is still buffered after this edge's handshake.
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                    dropped_s   = count_nxt_s;
                    count_nxt_s = 2'd0;
                    head_nxt_s  = tail_nxt_s;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                count_nxt_s = 2'd0;
                head_nxt_s  = tail_r;
            end
        endcase
    end

`ifdef FIFO_RX_ADAPT_STAT_EN
    // Words discarded this cycle: FLUSH pops plus buffered words dropped on entry.
    always_comb begin
        if (state_r == ST_FLUSH) begin
            discard_inc_s = {1'b0, pop_s};
        end else begin
            discard_inc_s = dropped_s;
        end
    end

    // Saturating handshake and discard counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stat_delivered_r <= 32'd0;
            stat_discarded_r <= 32'd0;
        end else begin
            stat_delivered_r <= sat_add(stat_delivered_r, {1'b0, accept_s});
            stat_discarded_r <= sat_add(stat_discarded_r, discard_inc_s);
        end
    end

    assign stat_delivered = stat_delivered_r;
    assign stat_discarded = stat_discarded_r;
`endif

    // State, pointers and registered stream outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_RUN;
            head_r      <= 1'b0;
            tail_r      <= 1'b0;
            count_r     <= 2'd0;
            entry_r[0]  <= '0;
            entry_r[1]  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            count_r     <= count_nxt_s;
            entry_r     <= entry_nxt_s;
            out_valid_r <= (count_nxt_s != 2'd0);
            out_data_r  <= entry_nxt_s[head_nxt_s];
        end
    end

endmodule

// File: tb/tb_fifo_rx_stream_adapter.sv
// Randomized bench for fifo_rx_stream_adapter against a queue-based model of the FIFO and stream.
module tb_fifo_rx_stream_adapter;

    localparam int DW = 32;

    logic          clk;
    logic          nrst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_do;
    logic          fifo_pop;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic          flush_done;
`ifdef FIFO_RX_ADAPT_STAT_EN
    logic [31:0]   stat_delivered;
    logic [31:0]   stat_discarded;
`endif

    fifo_rx_stream_adapter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .fifo_empty (fifo_empty),
        .fifo_do    (fifo_do),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .flush_done (flush_done)
`ifdef FIFO_RX_ADAPT_STAT_EN
        ,
        .stat_delivered (stat_delivered),
        .stat_discarded (stat_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: words waiting in the FIFO, words held by the adapter, and the mode.
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] buf_q [$];
    bit            mdl_flush = 1'b0;
    int            mdl_delivered = 0;
    int            mdl_discarded = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive at the falling edge, compare against the model, then advance the model.
    task automatic step(input bit gate, input bit rdy, input bit fl);
        bit exp_pop;
        bit exp_valid;
        @(negedge clk);
        fifo_empty = (src_q.size() == 0) || gate;
        fifo_do    = (src_q.size() != 0) ? src_q[0] : $urandom;
        out_ready  = rdy;
        flush      = fl;
        #1;
        exp_pop   = mdl_flush ? !fifo_empty : (!fifo_empty && buf_q.size() < 2);
        exp_valid = (buf_q.size() != 0);
        chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, exp_pop});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) chk("out_data", out_data, buf_q[0]);
        chk("flush_done", {31'd0, flush_done},
            {31'd0, mdl_flush && fifo_empty && buf_q.size() == 0});
        if (!mdl_flush) begin
            if (exp_valid && rdy) begin
                void'(buf_q.pop_front());
                mdl_delivered++;
            end
            if (exp_pop) buf_q.push_back(src_q.pop_front());
            if (fl) begin
                mdl_discarded += buf_q.size();
                buf_q.delete();
                mdl_flush = 1'b1;
            end
        end else begin
            if (exp_pop) begin
                void'(src_q.pop_front());
                mdl_discarded++;
            end
            if (!fl) mdl_flush = 1'b0;
        end
    endtask

    initial begin
        int cnt_pop;
        int cnt_valid;
        int pushed;
        int cycles;
        bit seen;

        nrst       = 1'b0;
        fifo_empty = 1'b0;
        fifo_do    = 32'hA5A5_A5A5;
        out_ready  = 1'b0;
        flush      = 1'b0;
        #12;
        chk("reset_pop", {31'd0, fifo_pop}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_flush_done", {31'd0, flush_done}, 32'd0);
        @(posedge clk);
        #2 nrst = 1'b1;

        // First word straight after reset release.
        src_q.push_back(32'hA5A5_A5A5);
        step(1'b0, 1'b1, 1'b0);
        chk("first_pop", {31'd0, fifo_pop}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_data", out_data, 32'hA5A5_A5A5);

        // Back-to-back burst, always ready.
        for (int i = 0; i < 8; i++) src_q.push_back(i);
        cnt_pop = 0;
        cnt_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            cnt_pop += fifo_pop;
            cnt_valid += out_valid;
            if (i >= 1 && i <= 8) chk("burst_data", out_data, i - 1);
        end
        chk("burst_pops", cnt_pop, 32'd8);
        chk("burst_valids", cnt_valid, 32'd8);

        // Stall: two words captured, then pops stop.
        for (int i = 0; i < 8; i++) src_q.push_back(i);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        chk("stall_pop", {31'd0, fifo_pop}, 32'd0);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, 32'd0);
        chk("stall_src_left", src_q.size(), 32'd6);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        chk("stall_drained", buf_q.size() + src_q.size(), 32'd0);

        // Flush with two buffered and three waiting in the FIFO.
        for (int i = 0; i < 5; i++) src_q.push_back(32'h100 + i);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        cnt_pop = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 0) chk("flush_valid_low", {31'd0, out_valid}, 32'd0);
            cnt_pop += fifo_pop;
        end
        chk("flush_pops", cnt_pop, 32'd3);
        chk("flush_done_set", {31'd0, flush_done}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        src_q.push_back(32'h1234_5678);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (out_valid && out_data == 32'h1234_5678) seen = 1'b1;
        end
        chk("post_flush_word", {31'd0, seen}, 32'd1);
`ifdef FIFO_RX_ADAPT_STAT_EN
        chk("stat_discarded", stat_discarded, 32'd5);
`endif

        // Randomized traffic with occasional short flushes.
        pushed = 0;
        cycles = 0;
        while ((pushed < 1000 || src_q.size() != 0 || buf_q.size() != 0) && cycles < 20000) begin
            if (pushed < 1000 && src_q.size() < 8 && $urandom_range(0, 1) == 1) begin
                src_q.push_back($urandom);
                pushed++;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0);
            cycles++;
        end
        chk("random_budget", {31'd0, cycles < 20000}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
`ifdef FIFO_RX_ADAPT_STAT_EN
        chk("stat_delivered", stat_delivered, mdl_delivered);
        chk("stat_discarded_total", stat_discarded, mdl_discarded);
`endif

        // Asynchronous reset with the buffer full.
        for (int i = 0; i < 8; i++) src_q.push_back(32'h200 + i);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_pop", {31'd0, fifo_pop}, 32'd0);
        buf_q.delete();
        mdl_flush = 1'b0;
        @(posedge clk);
        #2 nrst = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        chk("reset_drained", buf_q.size() + src_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
